parking_gate_ctrl: RTL

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_pkg.sv | 23 ++
 rtl/parking_debounce.sv | 60 ++++++
 rtl/parking_gate_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared lane-state type and default timing constants
//
// Purpose : lane FSM state enum and default DEB_CYCLES / CLEAR_CYCLES values
//           used by parking_debounce and parking_gate_ctrl.
// Ports   : none (package).

package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_OPEN   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_REJECT = 3'd5
    } lane_state_t;

    localparam int DEF_DEB_CYCLES   = 4;
    localparam int DEF_CLEAR_CYCLES = 8;

    localparam logic [15:0] REJECT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/parking_debounce.sv
// rtl/parking_debounce.sv - 2-FF synchroniser followed by a level debouncer
//
// Purpose : brings an asynchronous loop sensor into the clk domain and accepts
//           a level change only after it has been stable for DEB_CYCLES cycles.
// Ports   : clk    - rising-edge clock
//           reset  - asynchronous active-low reset
//           raw    - asynchronous loop sensor
//           rise   - one-cycle pulse when the debounced level goes 0 -> 1
//           fall   - one-cycle pulse when the debounced level goes 1 -> 0

module parking_debounce
    import parking_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] CNT_LAST = 4'(DEB_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic [3:0] cnt;

    // cnt holds how many consecutive cycles sync2 has disagreed with level;
    // the level flips on the DEB_CYCLES-th disagreeing cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= 4'd0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= 4'd0;
                    rise  <= sync2;
                    fall  <= ~sync2;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                cnt <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// rtl/parking_gate_ctrl.sv - entry/exit barrier controller for a car park
//
// Purpose : two independent lane FSMs (entry, exit) driven by debounced loop
//           sensors; issue one event pulse per car, open/hold the barrier and
//           reject entry when the zone for the car's class is full.
// Config  : PARKING_GATE_REJECT_CNT_EN - when defined, reject_cnt counts
//           rejected entries (saturating); otherwise it is tied to 0.
// Ports   : clk, reset (async active-low)
//           entry_loop, entry_tag_uni, exit_loop, exit_tag_uni - lane inputs
//           is_vacated_space, uni_is_vacated_space - zone vacancy flags
//           car_entered/is_uni_car_entered, car_exited/is_uni_car_exited
//           entry_barrier_open, exit_barrier_open, entry_reject, reject_cnt

module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        entry_loop,
    input  logic        entry_tag_uni,
    input  logic        exit_loop,
    input  logic        exit_tag_uni,
    input  logic        is_vacated_space,
    input  logic        uni_is_vacated_space,
    output logic        car_entered,
    output logic        is_uni_car_entered,
    output logic        car_exited,
    output logic        is_uni_car_exited,
    output logic        entry_barrier_open,
    output logic        exit_barrier_open,
    output logic        entry_reject,
    output logic [15:0] reject_cnt
);

    localparam logic [7:0] HOLD_LAST = 8'(CLEAR_CYCLES - 1);

    logic ent_rise, ent_fall;
    logic ext_rise, ext_fall;

    parking_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_entry (
        .clk   (clk),
        .reset (reset),
        .raw   (entry_loop),
        .rise  (ent_rise),
        .fall  (ent_fall)
    );

    parking_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_exit (
        .clk   (clk),
        .reset (reset),
        .raw   (exit_loop),
        .rise  (ext_rise),
        .fall  (ext_fall)
    );

    // ---------------------------------------------------------------- entry
    lane_state_t ent_state, ent_nxt;
    logic        ent_cls;
    logic [7:0]  ent_hold;
    logic        ent_vac;

    assign ent_vac = ent_cls ? uni_is_vacated_space : is_vacated_space;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_state <= ST_IDLE;
            ent_cls   <= 1'b0;
            ent_hold  <= 8'd0;
        end else begin
            ent_state <= ent_nxt;
            if (ent_state == ST_IDLE && ent_rise) begin
                ent_cls <= entry_tag_uni;
            end
            // hold timer only runs in HOLD, so every entry into HOLD starts at 0
            ent_hold <= (ent_state == ST_HOLD) ? ent_hold + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        ent_nxt            = ent_state;
        car_entered        = 1'b0;
        is_uni_car_entered = 1'b0;
        entry_barrier_open = 1'b0;
        entry_reject       = 1'b0;
        case (ent_state)
            ST_IDLE: begin
                if (ent_rise) ent_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                ent_nxt = ent_vac ? ST_PULSE : ST_REJECT;
            end
            ST_PULSE: begin
                car_entered        = 1'b1;
                is_uni_car_entered = ent_cls;
                ent_nxt            = ST_OPEN;
            end
            ST_OPEN: begin
                entry_barrier_open = 1'b1;
                if (ent_fall) ent_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                entry_barrier_open = 1'b1;
                // a following car re-enters OPEN without a new event pulse
                if (ent_rise)                   ent_nxt = ST_OPEN;
                else if (ent_hold == HOLD_LAST) ent_nxt = ST_IDLE;
            end
            ST_REJECT: begin
                entry_reject = 1'b1;
                // leave only once the rejected car has driven off the loop
                if (ent_fall) ent_nxt = ST_IDLE;
            end
            default: ent_nxt = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------------- exit
    lane_state_t ext_state, ext_nxt;
    logic        ext_cls;
    logic [7:0]  ext_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_state <= ST_IDLE;
            ext_cls   <= 1'b0;
            ext_hold  <= 8'd0;
        end else begin
            ext_state <= ext_nxt;
            if (ext_state == ST_IDLE && ext_rise) begin
                ext_cls <= exit_tag_uni;
            end
            ext_hold <= (ext_state == ST_HOLD) ? ext_hold + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        ext_nxt           = ext_state;
        car_exited        = 1'b0;
        is_uni_car_exited = 1'b0;
        exit_barrier_open = 1'b0;
        case (ext_state)
            ST_IDLE: begin
                if (ext_rise) ext_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                ext_nxt = ST_PULSE;
            end
            ST_PULSE: begin
                car_exited        = 1'b1;
                is_uni_car_exited = ext_cls;
                ext_nxt           = ST_OPEN;
            end
            ST_OPEN: begin
                exit_barrier_open = 1'b1;
                if (ext_fall) ext_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                exit_barrier_open = 1'b1;
                if (ext_rise)                   ext_nxt = ST_OPEN;
                else if (ext_hold == HOLD_LAST) ext_nxt = ST_IDLE;
            end
            default: ext_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------- reject counter
`ifdef PARKING_GATE_REJECT_CNT_EN
    logic [15:0] rej_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rej_q <= 16'd0;
        end else if (ent_state == ST_CHECK && !ent_vac && rej_q != REJECT_CNT_MAX) begin
            rej_q <= rej_q + 16'd1;
        end
    end

    assign reject_cnt = rej_q;
`else
    assign reject_cnt = 16'h0000;
`endif

endmodule
